umi_isolate_ctrl: RTL

- Clocked, multi-channel UMI power-domain isolation controller; successor to the combinational isolation buffer.
- Sits between an always-on UMI source and a switchable power domain.
- On request, it drains in-flight packets to their EOM boundary, then clamps all crossing signals and acknowledges.
- On release, it holds the clamp for a programmable settle time before passing traffic again.
- Adds a drain timeout with forced isolation and an error flag.

---
 rtl/umi_isolate_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/umi_isolate_ctrl.sv
// ---------------------------------------------------------------------------
// umi_isolate_ctrl
//
// Clocked isolation controller for N independent UMI channels crossing from
// an always-on source into a switchable power domain. On iso_req it lets
// every in-flight packet run to its EOM beat and then clamps the crossing.
// Once the crossing is clamped it raises iso_ack. When iso_req drops, the
// clamp is held for SETTLE cycles before traffic passes again. A drain that
// exceeds TIMEOUT cycles forces isolation and sets a sticky timeout_err.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   iso_req           isolation request from the power controller
//   iso_ack           high while the domain is fully clamped (registered)
//   timeout_err       sticky: a drain timed out and isolation was forced
//   umi_in_*          UMI source side (valid/cmd/dstaddr/srcaddr/data, ready out)
//   umi_out_*         UMI switched-domain side (valid/fields out, ready in)
//   Channel i occupies bits [i*W +: W] of every packed bus.
//
// The datapath is purely combinational. Only the state, the per-channel
// in-packet flags, the drain timer, the settle counter and the flags are
// registered.
// ---------------------------------------------------------------------------
module umi_isolate_ctrl #(
    parameter int N       = 2,
    parameter int CW      = 32,
    parameter int AW      = 64,
    parameter int DW      = 256,
    parameter int TIMEOUT = 1024,
    parameter int SETTLE  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            iso_req,
    output logic            iso_ack,
    output logic            timeout_err,
    input  logic [N-1:0]    umi_in_valid,
    input  logic [N*CW-1:0] umi_in_cmd,
    input  logic [N*AW-1:0] umi_in_dstaddr,
    input  logic [N*AW-1:0] umi_in_srcaddr,
    input  logic [N*DW-1:0] umi_in_data,
    output logic [N-1:0]    umi_in_ready,
    output logic [N-1:0]    umi_out_valid,
    output logic [N*CW-1:0] umi_out_cmd,
    output logic [N*AW-1:0] umi_out_dstaddr,
    output logic [N*AW-1:0] umi_out_srcaddr,
    output logic [N*DW-1:0] umi_out_data,
    input  logic [N-1:0]    umi_out_ready
);

    localparam int EOM_BIT = 22;
    // The drain timer only needs to reach TIMEOUT-1, the settle counter SETTLE-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_ACTIVE   = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_ISOLATED = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_inpkt;
    logic [TW-1:0]   r_timer;
    logic [SW-1:0]   r_settle;
    logic            r_iso_ack;
    logic            r_timeout_err;

    logic            w_clamp;
    logic [N-1:0]    w_pass;
    logic [N-1:0]    w_in_ready;
    logic [N-1:0]    w_hs;
    logic [N-1:0]    w_eom;
    logic [N-1:0]    w_inpkt_nxt;
    logic            w_timeout;
    logic            w_settled;

    // Fields are forced to zero whenever the domain is clamped; reset is
    // included so nothing leaks before the state register is initialised.
    assign w_clamp = reset || (r_state == ST_ISOLATED) || (r_state == ST_RELEASE);

    // A channel may hand over beats in ACTIVE, or in DRAIN only while it is
    // still finishing a packet. In DRAIN an idle channel is gated, so a new
    // SOM can never start there.
    always_comb begin
        w_pass      = '0;
        w_eom       = '0;
        w_inpkt_nxt = '0;
        for (int i = 0; i < N; i++) begin
            w_pass[i] = !reset &&
                        ((r_state == ST_ACTIVE) ||
                         ((r_state == ST_DRAIN) && r_inpkt[i]));
            w_eom[i]  = umi_in_cmd[i*CW + EOM_BIT];
        end
        for (int i = 0; i < N; i++) begin
            w_inpkt_nxt[i] = w_hs[i] ? !w_eom[i] : r_inpkt[i];
        end
    end

    assign w_in_ready = umi_out_ready & w_pass;
    assign w_hs       = umi_in_valid & w_in_ready;

    assign umi_in_ready    = w_in_ready;
    assign umi_out_valid   = umi_in_valid & w_pass;
    assign umi_out_cmd     = w_clamp ? '0 : umi_in_cmd;
    assign umi_out_dstaddr = w_clamp ? '0 : umi_in_dstaddr;
    assign umi_out_srcaddr = w_clamp ? '0 : umi_in_srcaddr;
    assign umi_out_data    = w_clamp ? '0 : umi_in_data;

    assign w_timeout = (TIMEOUT > 0) && (r_timer == TW'(TIMEOUT - 1));
    assign w_settled = (r_settle == SW'(SETTLE - 1));

    assign iso_ack     = r_iso_ack;
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_ISOLATED;
            r_inpkt       <= '0;
            r_timer       <= '0;
            r_settle      <= '0;
            r_iso_ack     <= 1'b1;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_ACTIVE: begin
                    r_inpkt <= w_inpkt_nxt;
                    if (iso_req) begin
                        r_state       <= ST_DRAIN;
                        r_timer       <= '0;
                        r_timeout_err <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // A withdrawn request wins over drain completion and
                    // keeps any partially sent packets alive.
                    if (!iso_req) begin
                        r_state <= ST_ACTIVE;
                        r_inpkt <= w_inpkt_nxt;
                    end else if (w_inpkt_nxt == '0) begin
                        r_state   <= ST_ISOLATED;
                        r_inpkt   <= '0;
                        r_iso_ack <= 1'b1;
                    end else if (w_timeout) begin
                        // Forced isolation: the stuck packets are abandoned.
                        r_state       <= ST_ISOLATED;
                        r_inpkt       <= '0;
                        r_iso_ack     <= 1'b1;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_inpkt <= w_inpkt_nxt;
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_ISOLATED: begin
                    if (!iso_req) begin
                        r_state   <= ST_RELEASE;
                        r_settle  <= '0;
                        r_iso_ack <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    if (iso_req) begin
                        r_state   <= ST_ISOLATED;
                        r_settle  <= '0;
                        r_iso_ack <= 1'b1;
                    end else if (w_settled) begin
                        r_state <= ST_ACTIVE;
                    end else begin
                        r_settle <= r_settle + SW'(1);
                    end
                end
                default: begin
                    r_state   <= ST_ISOLATED;
                    r_inpkt   <= '0;
                    r_iso_ack <= 1'b1;
                end
            endcase
        end
    end

endmodule
